// File: rtl/fcmp_pipe.sv
// rtl/fcmp_pipe.sv - two-stage handshaked binary32 compare (feq/flt/fle); FCMP_STATS_EN adds transfer counters
module fcmp_pipe #(
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      x1,
  input  logic [31:0]      x2,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             y,
  output logic             exception
`ifdef FCMP_STATS_EN
  ,
  output logic [CNT_W-1:0] cnt_cmp,
  output logic [CNT_W-1:0] cnt_exc
`endif
);

  // Only the fixed two-stage arrangement is implemented.
  generate
    if (STAGES != 2 || CNT_W < 1) begin : g_bad_params
      $error("fcmp_pipe: STAGES must be 2 and CNT_W at least 1");
    end
  endgenerate

  logic        s1_valid;
  logic [1:0]  s1_op;
  logic        s1_sa;
  logic        s1_sb;
  logic [30:0] s1_ma;
  logic [30:0] s1_mb;
  logic        s1_nan_a;
  logic        s1_nan_b;

  logic adv1;
  logic adv2;
  logic nan_a_in;
  logic nan_b_in;

  logic both_zero;
  logic eq;
  logic lt;
  logic exc_c;
  logic y_c;

  // Stage advance: the output register moves when empty or drained; S1 moves when S2 can take it.
  always_comb begin
    adv2     = !out_valid || out_ready;
    adv1     = !s1_valid || adv2;
    in_ready = adv1;
    nan_a_in = (x1[30:23] == 8'hFF) && (x1[22:0] != 23'd0);
    nan_b_in = (x2[30:23] == 8'hFF) && (x2[22:0] != 23'd0);
  end

  // S1 valid bit and output stage; reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      y         <= 1'b0;
      exception <= 1'b0;
    end else begin
      if (adv1) begin
        s1_valid <= in_valid;
      end
      if (adv2) begin
        out_valid <= s1_valid;
        y         <= s1_valid & y_c;
        exception <= s1_valid & exc_c;
      end
    end
  end

  // S1 operand latch; contents are ignored whenever s1_valid is low.
  always_ff @(posedge clk) begin
    if (adv1) begin
      s1_op    <= op;
      s1_sa    <= x1[31];
      s1_sb    <= x2[31];
      s1_ma    <= x1[30:0];
      s1_mb    <= x2[30:0];
      s1_nan_a <= nan_a_in;
      s1_nan_b <= nan_b_in;
    end
  end

  // Sign-magnitude ordering; +0 and -0 are equal, denormals and infinities compare by raw magnitude.
  always_comb begin
    both_zero = (s1_ma == 31'd0) && (s1_mb == 31'd0);
    eq        = both_zero || ((s1_sa == s1_sb) && (s1_ma == s1_mb));
    if (both_zero) begin
      lt = 1'b0;
    end else if (s1_sa != s1_sb) begin
      lt = s1_sa;
    end else if (!s1_sa) begin
      lt = (s1_ma < s1_mb);
    end else begin
      lt = (s1_ma > s1_mb);
    end
    exc_c = s1_nan_a || s1_nan_b || (s1_op == 2'b11);
    y_c   = 1'b0;
    if (!exc_c) begin
      case (s1_op)
        2'b00:   y_c = eq;
        2'b01:   y_c = lt;
        2'b10:   y_c = lt | eq;
        default: y_c = 1'b0;
      endcase
    end
  end

`ifdef FCMP_STATS_EN
  // Saturating counts of output transfers and of those flagged as exceptions.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_cmp <= '0;
      cnt_exc <= '0;
    end else if (out_valid && out_ready) begin
      if (cnt_cmp != {CNT_W{1'b1}}) begin
        cnt_cmp <= cnt_cmp + 1'b1;
      end
      if (exception && (cnt_exc != {CNT_W{1'b1}})) begin
        cnt_exc <= cnt_exc + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fcmp_pipe.sv
// tb/tb_fcmp_pipe.sv - scoreboard bench for fcmp_pipe
module tb_fcmp_pipe;

  localparam int CNT_W = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] x1 = '0;
  logic [31:0] x2 = '0;
  logic [1:0]  op = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        y;
  logic        exception;
`ifdef FCMP_STATS_EN
  logic [CNT_W-1:0] cnt_cmp;
  logic [CNT_W-1:0] cnt_exc;
`endif

  fcmp_pipe #(.STAGES(2), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x1        (x1),
    .x2        (x2),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .exception (exception)
`ifdef FCMP_STATS_EN
    ,
    .cnt_cmp   (cnt_cmp),
    .cnt_exc   (cnt_exc)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        y;
    logic        e;
    logic [31:0] cyc;
    logic        lat;
  } exp_t;

  exp_t        q[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] cyc = '0;
  logic        stream_phase = 1'b0;
  logic        saw_ir_low = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Called just after a posedge; returns just after the posedge that took the operands.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o,
                       input logic ey, input logic ee, input logic lat);
    exp_t e;
    x1 = a; x2 = b; op = o; in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e.y = ey; e.e = ee; e.cyc = cyc; e.lat = lat;
        q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    check("issue_timeout", 32'd1, 32'd0);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !out_valid) return;
    end
    check("drain_timeout", q.size(), 32'd0);
  endtask

  // Monitor: pops and compares on each transfer; checks hold-stability under backpressure.
  logic prev_stall = 1'b0;
  logic prev_y = 1'b0;
  logic prev_e = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (stream_phase && !in_ready) saw_ir_low = 1'b1;
    if (!rst && prev_stall && out_valid) begin
      check("hold_y", y, prev_y);
      check("hold_exc", exception, prev_e);
    end
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        check("y", y, e.y);
        check("exception", exception, e.e);
        if (e.lat) check("latency", cyc - e.cyc, 32'd2);
      end
    end
    prev_stall = out_valid && !out_ready;
    prev_y     = y;
    prev_e     = exception;
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_y", y, 1'b0);
    check("rst_exc", exception, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    issue(32'h3F800000, 32'h40000000, 2'b10, 1'b1, 1'b0, 1'b1);
    drain();
    @(posedge clk); #1;
    issue(32'h80000000, 32'h00000000, 2'b00, 1'b1, 1'b0, 1'b0);
    issue(32'h80000000, 32'h00000000, 2'b01, 1'b0, 1'b0, 1'b0);
    issue(32'hC0000000, 32'hBF800000, 2'b01, 1'b1, 1'b0, 1'b0);
    issue(32'h7F800000, 32'h7F7FFFFF, 2'b10, 1'b0, 1'b0, 1'b0);
    issue(32'h7FC00000, 32'h3F800000, 2'b10, 1'b0, 1'b1, 1'b0);
    issue(32'h3F800000, 32'h3F800000, 2'b11, 1'b0, 1'b1, 1'b0);
    drain();
    @(posedge clk); #1;

    stream_phase = 1'b1;
    fork
      begin
        issue(32'h3F800000, 32'h3F800000, 2'b00, 1'b1, 1'b0, 1'b0);
        issue(32'h3F800000, 32'h3F800000, 2'b01, 1'b0, 1'b0, 1'b0);
        issue(32'h3F800000, 32'h3F800000, 2'b10, 1'b1, 1'b0, 1'b0);
        issue(32'h00000001, 32'h00000002, 2'b01, 1'b1, 1'b0, 1'b0);
        issue(32'h80000001, 32'h80000002, 2'b01, 1'b0, 1'b0, 1'b0);
        issue(32'hFF800000, 32'h00000000, 2'b10, 1'b1, 1'b0, 1'b0);
        issue(32'h7F800001, 32'h7F800001, 2'b00, 1'b0, 1'b1, 1'b0);
        issue(32'hBF800000, 32'h3F800000, 2'b01, 1'b1, 1'b0, 1'b0);
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    stream_phase = 1'b0;
    check("in_ready_dropped", saw_ir_low, 1'b1);
    @(posedge clk); #1;

    out_ready = 1'b0;
    issue(32'h3F800000, 32'h40000000, 2'b01, 1'b1, 1'b0, 1'b0);
    issue(32'h40000000, 32'h3F800000, 2'b01, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    @(negedge clk);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;

`ifdef FCMP_STATS_EN
    check("stats_cnt_cmp_zero", cnt_cmp, 32'd0);
    issue(32'h3F800000, 32'h40000000, 2'b00, 1'b0, 1'b0, 1'b0);
    issue(32'h3F800000, 32'h40000000, 2'b01, 1'b1, 1'b0, 1'b0);
    issue(32'h7FC00000, 32'h40000000, 2'b01, 1'b0, 1'b1, 1'b0);
    issue(32'h40000000, 32'h40000000, 2'b10, 1'b1, 1'b0, 1'b0);
    issue(32'hC0000000, 32'h40000000, 2'b00, 1'b0, 1'b0, 1'b0);
    drain();
    check("cnt_cmp", cnt_cmp, 32'd5);
    check("cnt_exc", cnt_exc, 32'd1);
`endif

    check("queue_empty", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
